// File: rtl/modexp_sequencer.sv
// Square-and-multiply control FSM for the RSA modexp engine: walks the exponent
// MSB-first, issuing one MonPro command at a time, then a final reduction by 1.
module modexp_sequencer #(
    parameter int N         = 32,
    parameter int Nlog2     = 5,
    parameter int ABITS     = 8,
    parameter int ADDR_XBAR = 0,
    parameter int ADDR_ACC  = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     e,
    input  logic [Nlog2-1:0] e_idx,
    input  logic [Nlog2-1:0] mp_count,
    output logic             mm_start,
    output logic [ABITS-1:0] mm_a_addr,
    output logic [ABITS-1:0] mm_b_addr,
    output logic             mm_b_one,
    output logic [ABITS-1:0] mm_dst_addr,
    output logic [Nlog2-1:0] mm_mp_count,
    input  logic             mm_done,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SQ    = 3'd1;
    localparam logic [2:0] S_SQ_W  = 3'd2;
    localparam logic [2:0] S_MUL   = 3'd3;
    localparam logic [2:0] S_MUL_W = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
    localparam logic [2:0] S_FIN_W = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    WD_LAST = TW'(TIMEOUT - 1);
    localparam logic [ABITS-1:0] A_ACC   = ABITS'(ADDR_ACC);
    localparam logic [ABITS-1:0] A_XBAR  = ABITS'(ADDR_XBAR);

    logic [2:0]       state_q, state_d;
    logic [N-1:0]     e_l_q, e_l_d;
    logic [Nlog2-1:0] bit_idx_q, bit_idx_d;
    logic [TW-1:0]    wd_q, wd_d;
    logic             mm_start_q, mm_start_d;
    logic [ABITS-1:0] mm_a_addr_q, mm_a_addr_d;
    logic [ABITS-1:0] mm_b_addr_q, mm_b_addr_d;
    logic             mm_b_one_q, mm_b_one_d;
    logic [ABITS-1:0] mm_dst_addr_q, mm_dst_addr_d;
    logic [Nlog2-1:0] mm_mp_count_q, mm_mp_count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    always_comb begin
        state_d       = state_q;
        e_l_d         = e_l_q;
        bit_idx_d     = bit_idx_q;
        wd_d          = wd_q;
        mm_mp_count_d = mm_mp_count_q;
        err_d         = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    e_l_d         = e;
                    bit_idx_d     = e_idx;
                    mm_mp_count_d = mp_count;
                    err_d         = 1'b0;
                    state_d       = S_SQ;
                end
            end
            S_SQ:  begin wd_d = '0; state_d = S_SQ_W;  end
            S_MUL: begin wd_d = '0; state_d = S_MUL_W; end
            S_FIN: begin wd_d = '0; state_d = S_FIN_W; end
            S_SQ_W, S_MUL_W, S_FIN_W: begin
                // A reply arriving on the expiry cycle still counts as success.
                if (mm_done) begin
                    if (state_q == S_FIN_W) begin
                        state_d = S_DONE;
                    end else if (state_q == S_SQ_W && e_l_q[bit_idx_q]) begin
                        state_d = S_MUL;
                    end else if (bit_idx_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        bit_idx_d = bit_idx_q - Nlog2'(1);
                        state_d   = S_SQ;
                    end
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered on entry.
    always_comb begin
        mm_start_d    = 1'b0;
        mm_a_addr_d   = mm_a_addr_q;
        mm_b_addr_d   = mm_b_addr_q;
        mm_b_one_d    = mm_b_one_q;
        mm_dst_addr_d = mm_dst_addr_q;
        case (state_d)
            S_SQ: begin
                mm_start_d = 1'b1; mm_a_addr_d = A_ACC; mm_b_addr_d = A_ACC;
                mm_b_one_d = 1'b0; mm_dst_addr_d = A_ACC;
            end
            S_MUL: begin
                mm_start_d = 1'b1; mm_a_addr_d = A_ACC; mm_b_addr_d = A_XBAR;
                mm_b_one_d = 1'b0; mm_dst_addr_d = A_ACC;
            end
            S_FIN: begin
                mm_start_d = 1'b1; mm_a_addr_d = A_ACC; mm_b_addr_d = A_ACC;
                mm_b_one_d = 1'b1; mm_dst_addr_d = A_ACC;
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            e_l_q         <= '0;
            bit_idx_q     <= '0;
            wd_q          <= '0;
            mm_start_q    <= 1'b0;
            mm_a_addr_q   <= '0;
            mm_b_addr_q   <= '0;
            mm_b_one_q    <= 1'b0;
            mm_dst_addr_q <= '0;
            mm_mp_count_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            e_l_q         <= e_l_d;
            bit_idx_q     <= bit_idx_d;
            wd_q          <= wd_d;
            mm_start_q    <= mm_start_d;
            mm_a_addr_q   <= mm_a_addr_d;
            mm_b_addr_q   <= mm_b_addr_d;
            mm_b_one_q    <= mm_b_one_d;
            mm_dst_addr_q <= mm_dst_addr_d;
            mm_mp_count_q <= mm_mp_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign mm_start    = mm_start_q;
    assign mm_a_addr   = mm_a_addr_q;
    assign mm_b_addr   = mm_b_addr_q;
    assign mm_b_one    = mm_b_one_q;
    assign mm_dst_addr = mm_dst_addr_q;
    assign mm_mp_count = mm_mp_count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
